// File: rtl/ctrl_seq.sv
// ctrl_seq: sequenced control unit for the 9-bit ISA (idle/execute/load-wait/done).
// Optional macro CTRL_PERF_CNT_EN adds the CycleCount/InstrCount performance counters.
module ctrl_seq #(
  parameter int unsigned INSTR_W  = 9,
  parameter int unsigned OP_W     = 3,
  parameter int unsigned TARG_LSB = 2,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               InstrValid,
  input  logic               BranchCond,
  output logic               PcEn,
  output logic               RegWrEn,
  output logic               MemWrEn,
  output logic               LoadInst,
  output logic               StoreInst,
  output logic               BranchEn,
  output logic               Jump,
  output logic [1:0]         TargSel,
  output logic               Busy,
  output logic               Ack
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]        CycleCount,
  output logic [15:0]        InstrCount
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PERF_W = 16;

  // Opcode encodings of the 9-bit ISA; kXOR is the reduction-XOR catch-all.
  localparam logic [2:0] kADD = 3'b000;
  localparam logic [2:0] kLOD = 3'b001;
  localparam logic [2:0] kSTR = 3'b010;
  localparam logic [2:0] kBGZ = 3'b011;
  localparam logic [2:0] kOR  = 3'b100;
  localparam logic [2:0] kSLL = 3'b101;
  localparam logic [2:0] kXOR = 3'b110;
  localparam logic [2:0] kAND = 3'b111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_LWAIT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             ack_q, ack_d;
  logic [OP_W-1:0]  op;
  logic             halt;

  assign op      = Instruction[INSTR_W-1 -: OP_W];
  assign halt    = (Instruction == {INSTR_W{1'b1}});
  assign TargSel = Instruction[TARG_LSB+1:TARG_LSB];
  assign Busy    = (state_q == S_EXEC) || (state_q == S_LWAIT);
  assign Ack     = ack_q;

  // Next-state and combinational strobe decode.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ack_d      = ack_q;
    PcEn       = 1'b0;
    RegWrEn    = 1'b0;
    MemWrEn    = 1'b0;
    LoadInst   = 1'b0;
    StoreInst  = 1'b0;
    BranchEn   = 1'b0;
    Jump       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (InstrValid) begin
          if (halt) begin
            state_d = S_DONE;
            ack_d   = 1'b1;
          end else begin
            case (op)
              OP_W'(kSTR): begin
                MemWrEn   = 1'b1;
                StoreInst = 1'b1;
                PcEn      = 1'b1;
              end
              OP_W'(kBGZ): begin
                BranchEn = 1'b1;
                RegWrEn  = 1'b1;
                Jump     = BranchCond;
                PcEn     = 1'b1;
              end
              OP_W'(kLOD): begin
                LoadInst = 1'b1;
                if (MEM_LAT == 0) begin
                  RegWrEn = 1'b1;
                  PcEn    = 1'b1;
                end else begin
                  wait_cnt_d = CNT_W'(MEM_LAT);
                  state_d    = S_LWAIT;
                end
              end
              default: begin
                RegWrEn = 1'b1;
                PcEn    = 1'b1;
              end
            endcase
          end
        end
      end
      S_LWAIT: begin
        LoadInst   = 1'b1;
        wait_cnt_d = wait_cnt_q - CNT_W'(1);
        if (wait_cnt_q == CNT_W'(1)) begin
          RegWrEn = 1'b1;
          PcEn    = 1'b1;
          state_d = S_EXEC;
        end
      end
      default: begin
        if (Start) begin
          ack_d   = 1'b0;
          state_d = S_EXEC;
        end
      end
    endcase

    // A reset cycle must never fire a write, even mid-load.
    if (Reset) begin
      PcEn      = 1'b0;
      RegWrEn   = 1'b0;
      MemWrEn   = 1'b0;
      LoadInst  = 1'b0;
      StoreInst = 1'b0;
      BranchEn  = 1'b0;
      Jump      = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ack_q      <= ack_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] cyc_q, cyc_d;
  logic [PERF_W-1:0] instr_q, instr_d;

  assign CycleCount = cyc_q;
  assign InstrCount = instr_q;

  // Counters restart with each program launch and freeze outside EXEC/LWAIT.
  always_comb begin
    cyc_d   = cyc_q;
    instr_d = instr_q;
    if (Start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
      cyc_d   = '0;
      instr_d = '0;
    end else begin
      if (Busy) cyc_d = cyc_q + PERF_W'(1);
      if (PcEn) instr_d = instr_q + PERF_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      instr_q <= instr_d;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed, table-driven bench for ctrl_seq with MEM_LAT = 3, 0 and 2 instances.
module tb_ctrl_seq;

  localparam logic [2:0] kADD = 3'b000;
  localparam logic [2:0] kLOD = 3'b001;
  localparam logic [2:0] kSTR = 3'b010;
  localparam logic [2:0] kBGZ = 3'b011;
  localparam logic [2:0] kOR  = 3'b100;
  localparam logic [2:0] kSLL = 3'b101;
  localparam logic [2:0] kXOR = 3'b110;
  localparam logic [2:0] kAND = 3'b111;
  localparam logic [8:0] Z    = 9'h000;
  localparam logic [8:0] HALT = 9'h1FF;

  typedef struct packed {
    logic       pc, rw, mw, ld, st, br, jp;
    logic [1:0] ts;
    logic       busy, ack;
  } outs_t;

  typedef struct {
    string      name;
    logic       start;
    logic [8:0] instr;
    logic       iv;
    logic       bc;
    outs_t      exp;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start_r, iv_r, bc_r;
  logic [8:0] instr_r;
  int         sel;
  int         n_chk, n_pass;
  vec_t       tbl[$];

  wire [2:0] pc_w, rw_w, mw_w, ld_w, st_w, br_w, jp_w, busy_w, ack_w;
  wire [5:0] ts_w;
`ifdef CTRL_PERF_CNT_EN
  wire [15:0] cyc_w [3];
  wire [15:0] ins_w [3];
`endif

  always #5 Clk = ~Clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    ctrl_seq #(
      .INSTR_W (9),
      .OP_W    (3),
      .TARG_LSB(2),
      .MEM_LAT ((k == 0) ? 3 : ((k == 1) ? 0 : 2))
    ) u_dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (start_r && (sel == k)),
      .Instruction(instr_r),
      .InstrValid (iv_r && (sel == k)),
      .BranchCond (bc_r),
      .PcEn       (pc_w[k]),
      .RegWrEn    (rw_w[k]),
      .MemWrEn    (mw_w[k]),
      .LoadInst   (ld_w[k]),
      .StoreInst  (st_w[k]),
      .BranchEn   (br_w[k]),
      .Jump       (jp_w[k]),
      .TargSel    (ts_w[2*k+1:2*k]),
      .Busy       (busy_w[k]),
      .Ack        (ack_w[k])
`ifdef CTRL_PERF_CNT_EN
      ,
      .CycleCount (cyc_w[k]),
      .InstrCount (ins_w[k])
`endif
    );
  end

  function automatic outs_t o(bit pc, bit rw, bit mw, bit ld, bit st, bit br, bit jp,
                              bit [1:0] ts, bit busy, bit ack);
    return {pc, rw, mw, ld, st, br, jp, ts, busy, ack};
  endfunction

  function automatic outs_t cur();
    outs_t r;
    r.pc   = pc_w[sel];
    r.rw   = rw_w[sel];
    r.mw   = mw_w[sel];
    r.ld   = ld_w[sel];
    r.st   = st_w[sel];
    r.br   = br_w[sel];
    r.jp   = jp_w[sel];
    r.ts   = ts_w[2*sel +: 2];
    r.busy = busy_w[sel];
    r.ack  = ack_w[sel];
    return r;
  endfunction

  function automatic void add(string n, bit st, bit [8:0] ins, bit iv, bit bc, outs_t e);
    vec_t v;
    v.name  = n;
    v.start = st;
    v.instr = ins;
    v.iv    = iv;
    v.bc    = bc;
    v.exp   = e;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, outs_t exp);
    outs_t act;
    act = cur();
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: {pc rw mw ld st br jp ts busy ack} got %b want %b", name, act, exp);
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic check16(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask
`endif

  task automatic drive(bit st, bit [8:0] ins, bit iv, bit bc);
    start_r = st;
    instr_r = ins;
    iv_r    = iv;
    bc_r    = bc;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Apply one cycle of inputs, compare the same-cycle outputs, then advance.
  task automatic step(string name, bit st, bit [8:0] ins, bit iv, bit bc, outs_t exp);
    drive(st, ins, iv, bc);
    #3;
    check(name, exp);
    tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive(0, Z, 0, 0);
    repeat (2) tick();
    Reset = 1'b0;
  endtask

  outs_t idle0, exec_busy, alu, done_o;

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    sel     = 0;
    Reset   = 1'b1;
    drive(0, Z, 0, 0);
    idle0     = o(0,0,0,0,0,0,0,2'b00,0,0);
    exec_busy = o(0,0,0,0,0,0,0,2'b00,1,0);
    alu       = o(1,1,0,0,0,0,0,2'b00,1,0);
    done_o    = o(0,0,0,0,0,0,0,2'b00,0,1);

    // Main program on the MEM_LAT=3 instance.
    add("idle",           0, Z,                 0, 0, idle0);
    add("start_idle",     1, Z,                 0, 0, idle0);
    add("add",            0, {kADD, 6'b000101}, 1, 0, o(1,1,0,0,0,0,0,2'b01,1,0));
    add("str",            0, {kSTR, 6'b000000}, 1, 0, o(1,0,1,0,1,0,0,2'b00,1,0));
    add("bgz_taken",      0, {kBGZ, 6'b001000}, 1, 1, o(1,1,0,0,0,1,1,2'b10,1,0));
    add("bgz_not_taken",  0, {kBGZ, 6'b001000}, 1, 0, o(1,1,0,0,0,1,0,2'b10,1,0));
    add("exec_invalid",   0, {kADD, 6'b001100}, 0, 1, o(0,0,0,0,0,0,0,2'b11,1,0));
    add("or",             0, {kOR,  6'b000000}, 1, 0, alu);
    add("sll",            0, {kSLL, 6'b000000}, 1, 0, alu);
    add("xor",            0, {kXOR, 6'b000000}, 1, 0, alu);
    add("and_not_halt",   0, {kAND, 6'b111011}, 1, 1, o(1,1,0,0,0,0,0,2'b10,1,0));
    add("start_in_exec",  1, Z,                 0, 0, exec_busy);
    add("lod_issue",      0, {kLOD, 6'b000100}, 1, 0, o(0,0,0,1,0,0,0,2'b01,1,0));
    add("lwait_c1",       1, HALT,              1, 0, o(0,0,0,1,0,0,0,2'b11,1,0));
    add("lwait_c2",       0, {kSTR, 6'b000000}, 1, 0, o(0,0,0,1,0,0,0,2'b00,1,0));
    add("lwait_c3",       0, Z,                 0, 0, o(1,1,0,1,0,0,0,2'b00,1,0));
    add("exec_after_lod", 0, {kADD, 6'b000000}, 1, 0, alu);
    add("halt",           0, HALT,              1, 1, o(0,0,0,0,0,0,0,2'b11,1,0));

    do_reset();
    check("reset_state", idle0);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].name, tbl[i].start, tbl[i].instr, tbl[i].iv, tbl[i].bc, tbl[i].exp);

    // Ack holds in DONE until the next Start.
    for (int i = 0; i < 10; i++) step($sformatf("done_ack_%0d", i), 0, Z, 0, 0, done_o);
    step("start_done",      1, Z, 0, 0, done_o);
    step("exec_after_done", 0, Z, 0, 0, exec_busy);

    // Reset held two cycles mid-load: no write strobe, back to IDLE.
    step("lod_again",  0, {kLOD, 6'b000000}, 1, 0, o(0,0,0,1,0,0,0,2'b00,1,0));
    step("lwait_pre",  0, Z, 0, 0, o(0,0,0,1,0,0,0,2'b00,1,0));
    Reset = 1'b1;
    step("rst_in_lwait", 0, Z, 0, 0, exec_busy);
    step("rst_in_idle",  0, Z, 0, 0, idle0);
    Reset = 1'b0;
    step("post_rst_1",   0, {kADD, 6'b000000}, 1, 0, idle0);
    step("post_rst_2",   0, Z, 0, 0, idle0);

    // MEM_LAT=0: loads complete in a single EXEC cycle.
    sel = 1;
    do_reset();
    step("l0_start", 1, Z,                 0, 0, idle0);
    step("l0_lod",   0, {kLOD, 6'b001000}, 1, 0, o(1,1,0,1,0,0,0,2'b10,1,0));
    step("l0_add",   0, {kADD, 6'b000000}, 1, 0, alu);
    step("l0_lod2",  0, {kLOD, 6'b000000}, 1, 0, o(1,1,0,1,0,0,0,2'b00,1,0));
    step("l0_halt",  0, HALT,              1, 0, o(0,0,0,0,0,0,0,2'b11,1,0));
    step("l0_done",  0, Z,                 0, 0, done_o);

    // MEM_LAT=2 program: idle slot, 5 ALU ops, a load, then halt.
    sel = 2;
    do_reset();
    step("p_start", 1, Z, 0, 0, idle0);
    step("p_nv",    0, Z, 0, 0, exec_busy);
    for (int i = 0; i < 5; i++) step($sformatf("p_alu_%0d", i), 0, {kADD, 6'b000000}, 1, 0, alu);
    step("p_lod",   0, {kLOD, 6'b000000}, 1, 0, o(0,0,0,1,0,0,0,2'b00,1,0));
    step("p_lw_c1", 0, Z, 0, 0, o(0,0,0,1,0,0,0,2'b00,1,0));
    step("p_lw_c2", 0, Z, 0, 0, o(1,1,0,1,0,0,0,2'b00,1,0));
    step("p_halt",  0, HALT, 1, 0, o(0,0,0,0,0,0,0,2'b11,1,0));
    drive(0, Z, 0, 0);
    #3;
    check("p_done", done_o);
`ifdef CTRL_PERF_CNT_EN
    check16("p_cycle_count", cyc_w[2], 16'd10);
    check16("p_instr_count", ins_w[2], 16'd6);
    repeat (3) tick();
    check16("p_cycle_hold", cyc_w[2], 16'd10);
    check16("p_instr_hold", ins_w[2], 16'd6);
    drive(1, Z, 0, 0);
    tick();
    drive(0, Z, 0, 0);
    #3;
    check16("p_cycle_clear", cyc_w[2], 16'd0);
    check16("p_instr_clear", ins_w[2], 16'd0);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
